// File: rtl/ternary_neuron_acc_if.sv
// Chunk-in / result-out bundle of the ternary neuron accumulator.
//   pc_pos, pc_neg : per-chunk popcounts of +1 and -1 weighted inputs (0..15)
//   in_valid/in_last/in_ready : chunk handshake, in_last marks the neuron's final chunk
//   out_valid/out_ready : result handshake
//   out_trit, out_sum, out_sat : ternary activation, signed sum, per-neuron saturation
//   ovf : sticky chunk-count overflow
// slave  = accumulator side, master = producer/consumer side.
interface ternary_neuron_acc_if #(
  parameter int unsigned ACC_W = 8
);
  logic [3:0]       pc_pos;
  logic [3:0]       pc_neg;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_trit;
  logic [ACC_W-1:0] out_sum;
  logic             out_sat;
  logic             ovf;

  modport slave (
    input  pc_pos, pc_neg, in_valid, in_last, out_ready,
    output in_ready, out_valid, out_trit, out_sum, out_sat, ovf
  );

  modport master (
    output pc_pos, pc_neg, in_valid, in_last, out_ready,
    input  in_ready, out_valid, out_trit, out_sum, out_sat, ovf
  );
endinterface

// File: rtl/ternary_neuron_acc.sv
// Ternary neuron accumulator: sums (pc_pos - pc_neg) over the chunks of a
// neuron with a saturating signed accumulator, then thresholds the sum into
// a trit (01 = +1, 11 = -1, 00 = 0). One-deep registered result with
// valid/ready; in_ready is combinational so a draining result never costs a
// bubble.
//   clk, rst : clock and synchronous active-high reset
//   bus      : ternary_neuron_acc_if.slave (chunk input, result output, ovf)
module ternary_neuron_acc #(
  parameter int unsigned ACC_W      = 8,
  parameter int          TH_HI      = 2,
  parameter int          TH_LO      = -2,
  parameter int unsigned MAX_CHUNKS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ternary_neuron_acc_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(MAX_CHUNKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CHUNKS - 1);
  localparam logic signed [ACC_W-1:0] SUM_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SUM_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] TH_HI_S  = ACC_W'(TH_HI);
  localparam logic signed [ACC_W-1:0] TH_LO_S  = ACC_W'(TH_LO);
  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_NEG  = 2'b11;
  localparam logic [1:0] TRIT_ZERO = 2'b00;

  // HOLD means a result is sitting in the output register.
  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     sat_q, sat_d;
  logic                     ovf_q, ovf_d;
  logic [1:0]               trit_q, trit_d;
  logic signed [ACC_W-1:0]  sum_q, sum_d;
  logic                     osat_q, osat_d;

  logic                     in_ready_c;
  logic                     accept_c;
  logic                     consume_c;
  logic signed [4:0]        delta_c;
  logic signed [ACC_W:0]    sum_wide_c;
  logic                     clamp_c;
  logic signed [ACC_W-1:0]  sum_sat_c;
  logic [1:0]               trit_c;

  assign in_ready_c = (state_q == ACCUM) || bus.out_ready;
  assign accept_c   = bus.in_valid && in_ready_c;
  assign consume_c  = (state_q == HOLD) && bus.out_ready;

  // Saturating add: one guard bit catches overflow, which then clamps to the rail.
  always_comb begin
    delta_c    = {1'b0, bus.pc_pos} - {1'b0, bus.pc_neg};
    sum_wide_c = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-4){delta_c[4]}}, delta_c};
    clamp_c    = sum_wide_c[ACC_W] ^ sum_wide_c[ACC_W-1];
    sum_sat_c  = sum_wide_c[ACC_W-1:0];
    if (clamp_c) begin
      sum_sat_c = sum_wide_c[ACC_W] ? SUM_MIN : SUM_MAX;
    end
    trit_c = TRIT_ZERO;
    if (sum_sat_c >= TH_HI_S) begin
      trit_c = TRIT_POS;
    end else if (sum_sat_c <= TH_LO_S) begin
      trit_c = TRIT_NEG;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
      trit_q  <= TRIT_ZERO;
      sum_q   <= '0;
      osat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
      trit_q  <= trit_d;
      sum_q   <= sum_d;
      osat_q  <= osat_d;
    end
  end

  // Next-state: accumulate, close a neuron into the output register, drain.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    ovf_d   = ovf_q;
    trit_d  = trit_q;
    sum_d   = sum_q;
    osat_d  = osat_q;

    if (consume_c) begin
      state_d = ACCUM;
    end

    if (accept_c) begin
      if (bus.in_last) begin
        state_d = HOLD;
        sum_d   = sum_sat_c;
        trit_d  = trit_c;
        osat_d  = sat_q | clamp_c;
        acc_d   = '0;
        cnt_d   = '0;
        sat_d   = 1'b0;
      end else begin
        acc_d = sum_sat_c;
        sat_d = sat_q | clamp_c;
        // Counter parks at its top value once the fan-in limit is exceeded.
        if (cnt_q == CNT_LAST) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_trit  = trit_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_sat   = osat_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_ternary_neuron_acc.sv
// Bench for ternary_neuron_acc: directed scenarios plus randomized chunks,
// with expected results queued by a behavioural model and checked by an
// independent output monitor.
module tb_ternary_neuron_acc;

  localparam int ACC_W      = 6;
  localparam int TH_HI      = 2;
  localparam int TH_LO      = -2;
  localparam int MAX_CHUNKS = 4;
  localparam int SMAX       = (1 << (ACC_W - 1)) - 1;
  localparam int SMIN       = -(1 << (ACC_W - 1));

  typedef struct {
    int sum;
    int trit;
    int sat;
  } exp_t;

  logic clk;
  logic rst;
  ternary_neuron_acc_if #(.ACC_W(ACC_W)) bus ();

  ternary_neuron_acc #(
    .ACC_W(ACC_W), .TH_HI(TH_HI), .TH_LO(TH_LO), .MAX_CHUNKS(MAX_CHUNKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  // Reference model state
  int acc_m   = 0;
  int n_m     = 0;
  bit sat_m   = 1'b0;
  bit ovf_m   = 1'b0;
  bit rnd_ready = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int trit_of(input int s);
    if (s >= TH_HI) return 1;
    if (s <= TH_LO) return 3;
    return 0;
  endfunction

  task automatic model_accept(input int pos, input int neg, input bit last);
    int s;
    bit c;
    exp_t e;
    s = acc_m + pos - neg;
    c = 1'b0;
    if (s > SMAX) begin s = SMAX; c = 1'b1; end
    else if (s < SMIN) begin s = SMIN; c = 1'b1; end
    if (last) begin
      e.sum = s; e.trit = trit_of(s); e.sat = int'(sat_m | c);
      exp_q.push_back(e);
      acc_m = 0; n_m = 0; sat_m = 1'b0;
    end else begin
      acc_m = s; sat_m = sat_m | c; n_m++;
      if (n_m >= MAX_CHUNKS) ovf_m = 1'b1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_chunk(input int pos, input int neg, input bit last, input bit must_now = 1'b0);
    bit done;
    done = 1'b0;
    bus.pc_pos   = 4'(pos);
    bus.pc_neg   = 4'(neg);
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (must_now && i == 0) check("in_ready_same_cycle", int'(bus.in_ready), 1);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        model_accept(pos, neg, last);
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL send_chunk_timeout: got no accept, expected accept within 200 cycles");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    acc_m = 0; n_m = 0; sat_m = 1'b0; ovf_m = 1'b0;
    exp_q.delete();
  endtask

  // Out_ready randomiser, active only when enabled.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pop/compare on consume, hold-stability, sticky ovf.
  bit       hold_prev = 1'b0;
  int       prev_sum, prev_trit, prev_sat;
  exp_t     mon_e;
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      check("ovf", int'(bus.ovf), int'(ovf_m));
      if (hold_prev) begin
        check("hold_valid", int'(bus.out_valid), 1);
        check("hold_sum",   int'($signed(bus.out_sum)), prev_sum);
        check("hold_trit",  int'(bus.out_trit), prev_trit);
        check("hold_sat",   int'(bus.out_sat), prev_sat);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_result: got sum %0d, expected no result", $signed(bus.out_sum));
        end else begin
          mon_e = exp_q.pop_front();
          check("out_sum",  int'($signed(bus.out_sum)), mon_e.sum);
          check("out_trit", int'(bus.out_trit), mon_e.trit);
          check("out_sat",  int'(bus.out_sat), mon_e.sat);
        end
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      prev_sum  = int'($signed(bus.out_sum));
      prev_trit = int'(bus.out_trit);
      prev_sat  = int'(bus.out_sat);
    end
  end

  initial begin
    rst = 1'b1;
    bus.pc_pos = '0; bus.pc_neg = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_sum",   int'($signed(bus.out_sum)), 0);
    check("rst_out_trit",  int'(bus.out_trit), 0);
    check("rst_out_sat",   int'(bus.out_sat), 0);
    check("rst_in_ready",  int'(bus.in_ready), 1);
    @(posedge clk); #1;

    // Single-chunk neuron, one-cycle latency, single pulse
    send_chunk(5, 1, 1'b1);
    @(negedge clk);
    check("t1_valid_hi", int'(bus.out_valid), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_valid_lo", int'(bus.out_valid), 0);
    @(posedge clk); #1;

    // Multi-chunk negative, then a zero-trit neuron
    send_chunk(3, 4, 1'b0);
    send_chunk(2, 2, 1'b0);
    send_chunk(0, 1, 1'b1);
    send_chunk(1, 2, 1'b1);
    idle(2);

    // Backpressure with a held chunk, then release
    bus.out_ready = 1'b0;
    send_chunk(5, 0, 1'b1);
    bus.pc_pos = 4'd2; bus.pc_neg = 4'd1; bus.in_last = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_stall_in_ready", int'(bus.in_ready), 0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    send_chunk(2, 1, 1'b1, 1'b1);
    idle(2);

    // Positive saturation, then the flag clears for the next neuron
    send_chunk(15, 0, 1'b0);
    send_chunk(15, 0, 1'b0);
    send_chunk(15, 0, 1'b0);
    send_chunk(0, 0, 1'b1);
    send_chunk(1, 0, 1'b1);
    // Negative saturation
    send_chunk(0, 15, 1'b0);
    send_chunk(0, 15, 1'b0);
    send_chunk(0, 15, 1'b0);
    send_chunk(3, 0, 1'b1);
    idle(2);

    // Reset discards a partial neuron
    send_chunk(4, 1, 1'b0);
    send_chunk(4, 1, 1'b0);
    do_reset();
    send_chunk(1, 1, 1'b1);
    idle(2);

    // Chunk-count overflow is sticky until reset
    for (int i = 0; i < 5; i++) send_chunk(1, 0, 1'b0);
    send_chunk(1, 0, 1'b1);
    idle(3);
    check("t6_ovf_sticky", int'(bus.ovf), 1);
    do_reset();
    @(negedge clk);
    check("t6_ovf_cleared", int'(bus.ovf), 0);
    @(posedge clk); #1;

    // Randomized traffic with random backpressure and occasional resets
    rnd_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      int mode, pos, neg;
      mode = int'($urandom_range(0, 3));
      if (mode == 0) begin
        pos = int'($urandom_range(10, 15)); neg = int'($urandom_range(0, 3));
      end else if (mode == 1) begin
        pos = int'($urandom_range(0, 3));   neg = int'($urandom_range(10, 15));
      end else begin
        pos = int'($urandom_range(0, 15));  neg = int'($urandom_range(0, 15));
      end
      send_chunk(pos, neg, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) idle(1);
      if ($urandom_range(0, 79) == 0) do_reset();
    end

    // Drain
    rnd_ready = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    idle(1);
    check("drain_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
